// File: rtl/instr_pkg.sv
// ---------------------------------------------------------------------------
// instr_pkg
//   Shared definitions for the instruction fetch sequencer and its consumers:
//   addressing-mode codes, opcode map, instruction length and the sequencer
//   state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package instr_pkg;

  // Addressing modes carried in byte0[3:2] (mode_a) and byte1[1:0] (mode_b)
  localparam logic [1:0] MODE_REG = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_IDX = 2'b10;
  localparam logic [1:0] MODE_IMM = 2'b11;

  // Opcode map; OP_END in byte0 terminates the program
  localparam logic [3:0] OP_END = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_MOV = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_SLL = 4'h9;
  localparam logic [3:0] OP_SRL = 4'hA;
  localparam logic [3:0] OP_SRA = 4'hB;

  localparam int INSTR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_FETCH2 = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_DONE   = 3'd5
  } fetch_state_t;

  function automatic logic is_end_marker(input logic [7:0] byte0);
    return byte0[7:4] == OP_END;
  endfunction

endpackage

// File: rtl/instr_fetch_seq_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq_if
//   Bundles the ROM read port and the decoded-instruction valid/ready channel
//   of the instruction fetch sequencer.
//   master : sequencer side (drives ROM address/select and the instruction)
//   slave  : ROM + execute-datapath side (returns rom_data and instr_ready)
//   Signals:
//     rom_cs, rom_addr[ADDR_W], rom_data[DATA_W]
//     instr_valid, instr_ready, instr_pc[ADDR_W], opcode[4], mode_a[2],
//     mode_b[2], instr_word[3*DATA_W]
// ---------------------------------------------------------------------------
interface instr_fetch_seq_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) ();

  logic                  rom_cs;
  logic [ADDR_W-1:0]     rom_addr;
  logic [DATA_W-1:0]     rom_data;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [ADDR_W-1:0]     instr_pc;
  logic [3:0]            opcode;
  logic [1:0]            mode_a;
  logic [1:0]            mode_b;
  logic [3*DATA_W-1:0]   instr_word;

  modport master (
    output rom_cs, rom_addr, instr_valid, instr_pc, opcode, mode_a, mode_b,
           instr_word,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_cs, rom_addr, instr_valid, instr_pc, opcode, mode_a, mode_b,
           instr_word,
    output rom_data, instr_ready
  );

endinterface

// File: rtl/instr_fetch_seq.sv
// ---------------------------------------------------------------------------
// instr_fetch_seq
//   Program sequencer for the 64x8 instruction ROM. Fetches fixed 3-byte
//   instructions (three ROM reads, one per cycle), then presents the decoded
//   instruction on a valid/ready channel. Owns the program counter, the ROM
//   address/chip-select and end-of-program detection (address limit or an
//   OP_END opcode in byte0).
//   Ports:
//     clk    in   system clock, rising edge
//     rst    in   synchronous active-high reset
//     start  in   one-cycle pulse, starts a run from IDLE or DONE
//     busy   out  high in every state except IDLE/DONE
//     done   out  high in DONE
//     bus    master modport: ROM port + instruction channel
// ---------------------------------------------------------------------------
module instr_fetch_seq
  import instr_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 8,
  parameter int PROG_LEN   = 33,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  instr_fetch_seq_if.master bus
);

  localparam logic [ADDR_W:0]   PROG_END = (ADDR_W+1)'(PROG_LEN);
  localparam logic [ADDR_W-1:0] START_PC = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);
  // The limit check ahead of the first FETCH0 is a constant for START_PC
  localparam logic START_PAST_END = ({1'b0, START_PC} >= PROG_END);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] rom_addr, rom_addr_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic              pc_inc_past_end;
  logic              ld_b0, ld_b1, ld_b2;
  logic              issue;

  logic [DATA_W-1:0] byte0_p0;
  logic [DATA_W-1:0] byte1_p1;
  logic [DATA_W-1:0] byte2_p2;

  assign pc_inc          = pc + PC_STEP;
  assign pc_inc_past_end = ({1'b0, pc_inc} >= PROG_END);
  assign issue           = (state == ST_ISSUE);

  // Next-state, pc and ROM address update
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    rom_addr_nxt = rom_addr;
    ld_b0        = 1'b0;
    ld_b1        = 1'b0;
    ld_b2        = 1'b0;

    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          pc_nxt = START_PC;
          if (START_PAST_END) begin
            state_nxt    = ST_DONE;
            rom_addr_nxt = '0;
          end else begin
            state_nxt    = ST_FETCH0;
            rom_addr_nxt = START_PC;
          end
        end
      end
      ST_FETCH0: begin
        ld_b0 = 1'b1;
        if (is_end_marker(bus.rom_data)) begin
          // End marker: the partially fetched instruction is never issued
          state_nxt    = ST_DONE;
          rom_addr_nxt = '0;
        end else begin
          state_nxt    = ST_FETCH1;
          rom_addr_nxt = rom_addr + 1'b1;
        end
      end
      ST_FETCH1: begin
        ld_b1        = 1'b1;
        rom_addr_nxt = rom_addr + 1'b1;
        state_nxt    = ST_FETCH2;
      end
      ST_FETCH2: begin
        ld_b2     = 1'b1;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.instr_ready) begin
          pc_nxt = pc_inc;
          if (pc_inc_past_end) begin
            state_nxt    = ST_DONE;
            rom_addr_nxt = '0;
          end else begin
            state_nxt    = ST_FETCH0;
            rom_addr_nxt = pc_inc;
          end
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        rom_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= START_PC;
      rom_addr <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      rom_addr <= rom_addr_nxt;
    end
  end

  // ---- fetch stage boundary: ROM bytes captured, one per FETCH cycle ----
  // Byte registers are not reset; every output that depends on them is
  // qualified by ISSUE, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (ld_b0) byte0_p0 <= bus.rom_data;
    if (ld_b1) byte1_p1 <= bus.rom_data;
    if (ld_b2) byte2_p2 <= bus.rom_data;
  end

  // ---- issue stage boundary: combinational field unpacking ----
  assign bus.rom_cs      = (state == ST_FETCH0) || (state == ST_FETCH1) ||
                           (state == ST_FETCH2);
  assign bus.rom_addr    = rom_addr;
  assign bus.instr_valid = issue;
  assign bus.instr_pc    = issue ? pc : '0;
  assign bus.opcode      = issue ? byte0_p0[7:4] : 4'h0;
  assign bus.mode_a      = issue ? byte0_p0[3:2] : 2'b00;
  assign bus.mode_b      = issue ? byte1_p1[1:0] : 2'b00;
  assign bus.instr_word  = issue ? {byte0_p0, byte1_p1, byte2_p2} : '0;

  assign busy = (state != ST_IDLE) && (state != ST_DONE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;
  import instr_pkg::*;

  localparam int ADDR_W     = 6;
  localparam int DATA_W     = 8;
  localparam int PROG_LEN   = 33;
  localparam int START_ADDR = 0;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  instr_fetch_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  logic [7:0]  rom [64];
  logic [29:0] exp_q [$];   // {pc[5:0], word[23:0]} in issue order
  int          checks   = 0;
  int          failures = 0;

  assign bus.rom_data = rom[bus.rom_addr];

  instr_fetch_seq #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PROG_LEN  (PROG_LEN),
    .START_ADDR(START_ADDR)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .busy (busy),
    .done (done),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: walk the program as the specification describes it
  function automatic void build_model();
    int p;
    exp_q.delete();
    p = START_ADDR;
    while (p < PROG_LEN) begin
      if (rom[p][7:4] == OP_END) break;
      exp_q.push_back({6'(p), rom[p], rom[p+1], rom[p+2]});
      p += INSTR_BYTES;
    end
  endfunction

  task automatic load_program(input bit random_ends);
    for (int a = 0; a < 64; a++) rom[a] = 8'($urandom);
    for (int p = 0; p < PROG_LEN; p += 3) begin
      rom[p] = {4'($urandom_range(1, 11)), rom[p][3:0]};
      if (random_ends && $urandom_range(0, 11) == 0) rom[p][7:4] = OP_END;
    end
    if (!random_ends) begin
      rom[0]  = 8'h10; rom[1]  = 8'h00; rom[2]  = 8'h01;
      rom[12] = 8'h58; rom[13] = 8'h42; rom[14] = 8'h50;
      rom[21] = 8'h8C; rom[22] = 8'h00; rom[23] = 8'h00;
      rom[33] = 8'hFF;
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_done);
    check_eq({tag, ":valid"}, bus.instr_valid, 0);
    check_eq({tag, ":rom_cs"}, bus.rom_cs, 0);
    check_eq({tag, ":rom_addr"}, bus.rom_addr, 0);
    check_eq({tag, ":instr_pc"}, bus.instr_pc, 0);
    check_eq({tag, ":opcode"}, bus.opcode, 0);
    check_eq({tag, ":modes"}, {bus.mode_a, bus.mode_b}, 0);
    check_eq({tag, ":word"}, bus.instr_word, 0);
    check_eq({tag, ":busy"}, busy, 0);
    check_eq({tag, ":done"}, done, exp_done);
  endtask

  // ready_mode: 0 = always ready, 1 = random, 2 = stall 5 cycles at pc 21
  task automatic run(input int ready_mode, input bit poke, input int max_cyc,
                     input string tag, output int n_xfer);
    int          first_vld, exp_n, stall;
    bit          chk24;
    logic [29:0] e;
    logic [23:0] w;
    build_model();
    exp_n = exp_q.size();
    first_vld = -1; n_xfer = 0; stall = 0; chk24 = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      case (ready_mode)
        0: bus.instr_ready = 1'b1;
        1: bus.instr_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus.instr_valid && bus.instr_pc == 6'd21 && stall < 5) begin
            bus.instr_ready = 1'b0;
            stall++;
          end else begin
            bus.instr_ready = 1'b1;
          end
        end
      endcase
      start = poke && (cyc == 3 || cyc == 4);
      @(negedge clk);
      if (chk24) begin
        check_eq({tag, ":fetch_after_stall_cs"}, bus.rom_cs, 1);
        check_eq({tag, ":fetch_after_stall_addr"}, bus.rom_addr, 24);
        chk24 = 0;
      end
      if (bus.rom_cs)
        check_eq({tag, ":cs_addr_in_prog"}, bus.rom_addr < PROG_LEN, 1);
      if (bus.instr_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (exp_q.size() == 0) begin
          check_eq({tag, ":spurious_valid"}, bus.instr_valid, 0);
        end else begin
          e = exp_q[0];
          w = e[23:0];
          check_eq({tag, ":pc"}, bus.instr_pc, e[29:24]);
          check_eq({tag, ":word"}, bus.instr_word, w);
          check_eq({tag, ":opcode"}, bus.opcode, w[23:20]);
          check_eq({tag, ":mode_a"}, bus.mode_a, w[19:18]);
          check_eq({tag, ":mode_b"}, bus.mode_b, w[9:8]);
          check_eq({tag, ":busy_in_issue"}, busy, 1);
          if (ready_mode != 1 && bus.instr_pc == 6'd12)
            check_eq({tag, ":pc12_word"}, bus.instr_word, 24'h584250);
          if (ready_mode == 2 && bus.instr_pc == 6'd21 && !bus.instr_ready) begin
            check_eq({tag, ":stall_word"}, bus.instr_word, 24'h8C0000);
            check_eq({tag, ":stall_cs"}, bus.rom_cs, 0);
          end
          if (bus.instr_ready) begin
            if (ready_mode == 2 && bus.instr_pc == 6'd21) chk24 = 1;
            void'(exp_q.pop_front());
            n_xfer++;
          end
        end
      end
      if (done) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.instr_ready = 1'b0;
    check_eq({tag, ":xfer_count"}, n_xfer, exp_n);
    if (exp_n > 0) check_eq({tag, ":first_valid_cycle"}, first_vld, 4);
    if (ready_mode == 2) check_eq({tag, ":stall_cycles"}, stall, 5);
    check_quiet({tag, ":end"}, 1'b1);
  endtask

  initial begin
    int          n;
    logic [7:0]  saved;
    rst = 1'b1;
    start = 1'b0;
    bus.instr_ready = 1'b0;
    load_program(1'b0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("in_reset", 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_reset", 1'b0);

    // Full run, ready high: first issue and all eleven transfers
    run(0, 1'b0, 200, "full_run", n);
    check_eq("full_run:n11", n, 11);

    // Backpressure at pc 21
    run(2, 1'b0, 300, "backpressure", n);

    // End marker at pc 6
    saved = rom[6];
    rom[6] = 8'h00;
    run(0, 1'b0, 200, "end_marker", n);
    check_eq("end_marker:n2", n, 2);
    rom[6] = saved;

    // Reset during FETCH1
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_fetch1:busy_before", busy, 1);
    check_eq("rst_fetch1:addr_before", bus.rom_addr, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_fetch1", 1'b0);

    // Reset during ISSUE with valid high
    bus.instr_ready = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.instr_valid) break;
    end
    check_eq("rst_issue:reached_issue", bus.instr_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_issue", 1'b0);
    run(0, 1'b0, 200, "restart_after_rst", n);

    // start pulses during FETCH2 and ISSUE are ignored; start in DONE reruns
    run(0, 1'b1, 200, "start_ignored", n);
    check_eq("start_ignored:n11", n, 11);
    run(0, 1'b0, 200, "rerun_from_done", n);

    // Randomized programs and random ready
    for (int k = 0; k < 6; k++) begin
      load_program(1'b1);
      run(1, 1'b0, 1000, $sformatf("random%0d", k), n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
